// File: rtl/line_dispatch_sched.sv
// line_dispatch_sched: shares one line-drawing geometry unit among NUM_REQ
// requesters. Commands are arbitrated round-robin into a small FIFO and are
// dispatched one at a time. The block holds the coordinates stable, pulses
// geo_start and follows geo_pixel_valid to detect completion or a start
// timeout.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_cmd             44 bits per requester: {x1, y1, x2, y2, color}
//   geo_x1..geo_color   registered command presented to the geometry unit
//   geo_start           one-cycle start pulse
//   geo_pixel_valid     geometry unit is drawing
//   busy                FSM is not idle
//   active_id           requester index of the command in flight
//   fifo_count          command FIFO occupancy
//   lines_done          completed-line counter (wraps)
//   timeout_err         sticky start-timeout flag
module line_dispatch_sched #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned WAIT_TIMEOUT = 8
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NUM_REQ-1:0]                                req_valid,
    output logic [NUM_REQ-1:0]                                req_ready,
    input  logic [44*NUM_REQ-1:0]                             req_cmd,
    output logic [8:0]                                        geo_x1,
    output logic [8:0]                                        geo_y1,
    output logic [8:0]                                        geo_x2,
    output logic [8:0]                                        geo_y2,
    output logic [7:0]                                        geo_color,
    output logic                                              geo_start,
    input  logic                                              geo_pixel_valid,
    output logic                                              busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]  active_id,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]                   fifo_count,
    output logic [15:0]                                       lines_done,
    output logic                                              timeout_err
);

    localparam int unsigned CMD_W = 44;
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TO_W  = $clog2(WAIT_TIMEOUT + 1);

    typedef struct packed {
        logic [8:0] x1;
        logic [8:0] y1;
        logic [8:0] x2;
        logic [8:0] y2;
        logic [7:0] color;
    } line_cmd_t;

    typedef struct packed {
        line_cmd_t         cmd;
        logic [ID_W-1:0]   id;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        START      = 2'd1,
        WAIT_BEGIN = 2'd2,
        DRAWING    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ID_W-1:0]   rr_ptr;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    line_cmd_t         grant_cmd;
    logic              push;
    logic              pop;

    fifo_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    fifo_entry_t       head;

    logic [TO_W-1:0]   wait_cnt_q;
    logic [TO_W-1:0]   wait_cnt_d;
    logic [15:0]       lines_d;
    logic              timeout_d;

    // Round-robin arbiter: first valid requester at or after rr_ptr.
    // Gated by the registered count only, so no path from geo_pixel_valid.
    always_comb begin : arb_comb
        int unsigned cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (reset && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = (32'(rr_ptr) + k) % NUM_REQ;
                if (!grant_vld && req_valid[ID_W'(cand)]) begin
                    grant_vld = 1'b1;
                    grant_idx = ID_W'(cand);
                end
            end
        end
    end

    // One-hot ready for the granted requester only.
    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_cmd = req_cmd[int'(grant_idx) * CMD_W +: CMD_W];
    assign push      = grant_vld;
    assign head      = mem[rd_ptr];

    // FIFO storage; contents need no reset, validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{cmd: grant_cmd, id: grant_idx};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state plus next values of the counters and sticky flag.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        wait_cnt_d = wait_cnt_q;
        lines_d    = lines_done;
        timeout_d  = timeout_err;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT_BEGIN;
            end
            WAIT_BEGIN: begin
                if (geo_pixel_valid) begin
                    state_d = DRAWING;
                end else if (wait_cnt_q == TO_W'(WAIT_TIMEOUT - 1)) begin
                    // Counter would reach WAIT_TIMEOUT on this cycle.
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            DRAWING: begin
                if (!geo_pixel_valid) begin
                    lines_d = lines_done + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rr_ptr      <= '0;
            geo_x1      <= '0;
            geo_y1      <= '0;
            geo_x2      <= '0;
            geo_y2      <= '0;
            geo_color   <= '0;
            active_id   <= '0;
            geo_start   <= 1'b0;
            busy        <= 1'b0;
            wait_cnt_q  <= '0;
            lines_done  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                // Endpoints only change here and stay put for the whole draw.
                geo_x1    <= head.cmd.x1;
                geo_y1    <= head.cmd.y1;
                geo_x2    <= head.cmd.x2;
                geo_y2    <= head.cmd.y2;
                geo_color <= head.cmd.color;
                active_id <= head.id;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            geo_start   <= (state_d == START);
            busy        <= (state_d != IDLE);
            wait_cnt_q  <= wait_cnt_d;
            lines_done  <= lines_d;
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: tb/tb_line_dispatch_sched.sv
// tb_line_dispatch_sched: scoreboard bench for line_dispatch_sched with a
// behavioural geometry-unit model (one INIT cycle, then max(|dx|,|dy|)+1
// cycles of pixel_valid).
module tb_line_dispatch_sched;

    localparam int unsigned NUM_REQ      = 2;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned WAIT_TIMEOUT = 8;
    localparam int unsigned ID_W         = 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [44*NUM_REQ-1:0]  req_cmd;
    logic [8:0]             geo_x1, geo_y1, geo_x2, geo_y2;
    logic [7:0]             geo_color;
    logic                   geo_start;
    logic                   geo_pixel_valid;
    logic                   busy;
    logic [ID_W-1:0]        active_id;
    logic [2:0]             fifo_count;
    logic [15:0]            lines_done;
    logic                   timeout_err;

    int                     n_checks = 0;
    int                     n_errors = 0;
    logic [44+ID_W-1:0]     exp_q[$];
    logic [43:0]            cur_cmd;
    logic                   cur_vld = 1'b0;
    int                     exp_lines = 0;
    logic                   pv_prev = 1'b0;
    logic                   mute = 1'b0;
    logic                   m_init;
    int                     m_left;

    always #5 clk = ~clk;

    line_dispatch_sched #(
        .NUM_REQ      (NUM_REQ),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cmd         (req_cmd),
        .geo_x1          (geo_x1),
        .geo_y1          (geo_y1),
        .geo_x2          (geo_x2),
        .geo_y2          (geo_y2),
        .geo_color       (geo_color),
        .geo_start       (geo_start),
        .geo_pixel_valid (geo_pixel_valid),
        .busy            (busy),
        .active_id       (active_id),
        .fifo_count      (fifo_count),
        .lines_done      (lines_done),
        .timeout_err     (timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] mk(input int x1, input int y1, input int x2, input int y2, input int c);
        return {9'(x1), 9'(y1), 9'(x2), 9'(y2), 8'(c)};
    endfunction

    function automatic int line_len(input logic [8:0] a, input logic [8:0] b,
                                    input logic [8:0] c, input logic [8:0] d);
        int dx, dy;
        dx = (c > a) ? int'(c - a) : int'(a - c);
        dy = (d > b) ? int'(d - b) : int'(b - d);
        return ((dx > dy) ? dx : dy) + 1;
    endfunction

    // Geometry unit model: INIT the cycle after start, then draw.
    always @(posedge clk) begin
        if (!reset) begin
            m_init          <= 1'b0;
            m_left          <= 0;
            geo_pixel_valid <= 1'b0;
        end else begin
            m_init <= geo_start && !mute;
            if (m_init) begin
                geo_pixel_valid <= 1'b1;
                m_left          <= line_len(geo_x1, geo_y1, geo_x2, geo_y2) - 1;
            end else if (geo_pixel_valid && m_left != 0) begin
                m_left <= m_left - 1;
            end else begin
                geo_pixel_valid <= 1'b0;
            end
        end
    end

    // Scoreboard: push on handshake, pop and compare on geo_start.
    always @(negedge clk) begin
        logic [44+ID_W-1:0] e;
        if (!reset) begin
            exp_q.delete();
            cur_vld   = 1'b0;
            exp_lines = 0;
            pv_prev   = 1'b0;
        end else begin
            check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            check("fifo_bound", 64'(fifo_count <= 3'(FIFO_DEPTH)), 64'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({req_cmd[44*i +: 44], ID_W'(i)});
                end
            end
            if (geo_start) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dispatch_cmd", 64'({geo_x1, geo_y1, geo_x2, geo_y2, geo_color}), 64'(e[44+ID_W-1:ID_W]));
                    check("dispatch_id", 64'(active_id), 64'(e[ID_W-1:0]));
                    cur_cmd = e[44+ID_W-1:ID_W];
                    cur_vld = 1'b1;
                end
            end
            if (geo_pixel_valid && cur_vld) begin
                check("geo_hold", 64'({geo_x1, geo_y1, geo_x2, geo_y2, geo_color}), 64'(cur_cmd));
            end
            if (pv_prev && !geo_pixel_valid) begin
                exp_lines++;
            end
            pv_prev = geo_pixel_valid;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        tick(2);
        reset = 1'b1;
        tick();
    endtask

    task automatic send(input int id, input logic [43:0] cmd, input int budget);
        bit done;
        done = 1'b0;
        req_cmd[44*id +: 44] = cmd;
        req_valid[id]        = 1'b1;
        #1;
        for (int i = 0; i < budget && !done; i++) begin
            if (req_ready[id]) done = 1'b1;
            tick();
        end
        req_valid[id] = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (i < budget && (busy || fifo_count != 0 || geo_pixel_valid)) begin
            tick();
            i++;
        end
        check("idle_reached", 64'(i < budget), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int acc, cyc, g, blocked, n;
        reset     = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        tick(2);

        // Reset state, with requests pending while reset is held.
        req_valid = 2'b11;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(geo_start), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_lines", 64'(lines_done), 64'd0);
        check("rst_tmo", 64'(timeout_err), 64'd0);
        check("rst_geo", 64'({geo_x1, geo_y1, geo_x2, geo_y2, geo_color, active_id}), 64'd0);
        req_valid = '0;
        reset     = 1'b1;
        tick();

        // Single command, cycle-accurate dispatch.
        req_cmd[43:0] = mk(10, 10, 14, 12, 8'hAA);
        req_valid     = 2'b01;
        #1;
        check("t1_ready_c0", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0;
        check("t1_start_c1", 64'(geo_start), 64'd0);
        check("t1_count_c1", 64'(fifo_count), 64'd1);
        tick();
        check("t1_start_c2", 64'(geo_start), 64'd1);
        check("t1_busy_c2", 64'(busy), 64'd1);
        tick();
        check("t1_start_c3", 64'(geo_start), 64'd0);
        wait_idle(100);
        check("t1_lines", 64'(lines_done), 64'd1);
        check("t1_lines_sb", 64'(lines_done), 64'(exp_lines));
        check("t1_geo_held", 64'({geo_x1, geo_y1, geo_x2, geo_y2, geo_color}), 64'(mk(10, 10, 14, 12, 8'hAA)));

        // Two requesters continuously valid: alternating grants.
        do_reset();
        req_cmd[43:0]  = mk(20, 20, 22, 21, 8'h10);
        req_cmd[87:44] = mk(30, 30, 33, 30, 8'h20);
        req_valid      = 2'b11;
        acc = 0;
        cyc = 0;
        while (acc < 4 && cyc < 50) begin
            #1;
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                check("t2_order", 64'(g), 64'(acc % 2));
                tick();
                acc++;
                req_cmd[44*g +: 44] = mk(40 + acc, 40, 42 + acc, 43, acc);
            end else begin
                tick();
            end
            cyc++;
        end
        req_valid = '0;
        check("t2_accepts", 64'(acc), 64'd4);
        wait_idle(300);
        check("t2_lines", 64'(lines_done), 64'd4);
        check("t2_lines_sb", 64'(lines_done), 64'(exp_lines));

        // Fill the FIFO behind a long line; fifth request must stall.
        send(0, mk(0, 0, 200, 0, 8'h33), 10);
        tick(2);
        for (int k = 0; k < 4; k++) send(1, mk(100 + k, 5, 101 + k, 6, k), 10);
        check("t3_full", 64'(fifo_count), 64'd4);
        req_cmd[87:44] = mk(7, 7, 9, 9, 8'h77);
        req_valid[1]   = 1'b1;
        #1;
        check("t3_ready_full", 64'(req_ready), 64'd0);
        blocked = 0;
        while (!req_ready[1] && blocked < 400) begin
            tick();
            #1;
            blocked++;
        end
        check("t3_blocked_long", 64'(blocked > 150 && blocked < 400), 64'd1);
        check("t3_count_at_grant", 64'(fifo_count), 64'd3);
        tick();
        req_valid = '0;
        wait_idle(600);
        check("t3_lines", 64'(lines_done), 64'd10);
        check("t3_lines_sb", 64'(lines_done), 64'(exp_lines));

        // Degenerate line counts as one.
        send(0, mk(50, 50, 50, 50, 8'h01), 10);
        wait_idle(50);
        check("t4_lines", 64'(lines_done), 64'd11);
        check("t4_busy", 64'(busy), 64'd0);

        // Start timeout, then the queued command dispatches.
        mute = 1'b1;
        send(0, mk(1, 1, 3, 3, 8'h55), 10);
        send(1, mk(2, 2, 4, 4, 8'h66), 10);
        n = 0;
        while (!geo_start && n < 20) begin
            tick();
            n++;
        end
        check("t5_start_seen", 64'(n < 20), 64'd1);
        tick(8);
        check("t5_tmo_early", 64'(timeout_err), 64'd0);
        tick();
        check("t5_tmo_set", 64'(timeout_err), 64'd1);
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_lines_same", 64'(lines_done), 64'd11);
        mute = 1'b0;
        tick();
        check("t5_next_start", 64'(geo_start), 64'd1);
        check("t5_next_id", 64'(active_id), 64'd1);
        wait_idle(50);
        check("t5_lines", 64'(lines_done), 64'd12);
        check("t5_tmo_sticky", 64'(timeout_err), 64'd1);

        // Reset mid-draw with three commands queued.
        send(1, mk(0, 0, 200, 0, 8'hC3), 10);
        for (int k = 0; k < 3; k++) send(0, mk(80 + k, 8, 82 + k, 9, k), 10);
        n = 0;
        while (!geo_pixel_valid && n < 20) begin
            tick();
            n++;
        end
        tick(5);
        check("t6_queued", 64'(fifo_count), 64'd3);
        reset = 1'b0;
        tick();
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_count", 64'(fifo_count), 64'd0);
        check("t6_lines", 64'(lines_done), 64'd0);
        check("t6_tmo", 64'(timeout_err), 64'd0);
        check("t6_start", 64'(geo_start), 64'd0);
        check("t6_ready", 64'(req_ready), 64'd0);
        check("t6_geo", 64'({geo_x1, geo_y1, geo_x2, geo_y2, geo_color, active_id}), 64'd0);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (geo_start) n++;
        end
        check("t6_no_start", 64'(n), 64'd0);
        send(0, mk(60, 60, 61, 62, 8'h9C), 10);
        wait_idle(50);
        check("t6_new_lines", 64'(lines_done), 64'd1);
        check("t6_new_lines_sb", 64'(lines_done), 64'(exp_lines));

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
